// File: rtl/pll_lock_reset_sequencer.sv
// pll_lock_reset_sequencer
//
// Supervises the PLL lock output and sequences the system resets. Runs from
// the free-running reference clock, never from a PLL output.
//
// Flow: PLL_RST (pll_rst pulse) -> WAIT_LOCK (bounded by a timeout, with
// retries) -> STABLE (debounce the lock) -> RELEASE (staggered domain reset
// release, bit 0 first) -> RUN. When the retries run out the block parks in
// FAIL. Loss of lock during RELEASE or RUN asserts every domain reset again
// and re-arms the PLL.
//
// Ports:
//   clk            in   free-running reference clock
//   rst            in   synchronous, active-high reset
//   pll_locked     in   PLL lock indicator, asynchronous to clk
//   sw_relock      in   single-cycle request to restart the sequence
//   pll_rst        out  PLL reset, active high
//   domain_rst_out out  per-domain resets, active high, bit 0 released first
//   ready          out  all domains out of reset with lock held
//   fail           out  retries exhausted
//   lock_lost      out  sticky: lock dropped after RUN was reached
//   retry_count    out  failed lock attempts in the current episode
//
// Every output comes straight from a register.

module pll_lock_reset_sequencer #(
    parameter int SYNC_STAGES         = 2,
    parameter int PLL_RST_CYCLES      = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 65536,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int NUM_DOMAINS         = 3,
    parameter int STAGE_GAP_CYCLES    = 8,
    parameter int MAX_RETRIES         = 3,
    localparam int RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   pll_locked,
    input  logic                   sw_relock,
    output logic                   pll_rst,
    output logic [NUM_DOMAINS-1:0] domain_rst_out,
    output logic                   ready,
    output logic                   fail,
    output logic                   lock_lost,
    output logic [RETRY_W-1:0]     retry_count
);

    // The shared counter must cover the longest interval it ever times.
    localparam int CNT_MAX_A = (PLL_RST_CYCLES > LOCK_TIMEOUT_CYCLES) ? PLL_RST_CYCLES : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_MAX_B = (LOCK_STABLE_CYCLES > STAGE_GAP_CYCLES) ? LOCK_STABLE_CYCLES : STAGE_GAP_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > CNT_MAX_B) ? CNT_MAX_A : CNT_MAX_B;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);

    typedef enum logic [2:0] {
        S_PLL_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RELEASE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       cnt_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   pll_rst_q;
    logic [NUM_DOMAINS-1:0] domain_rst_q;
    logic                   ready_q;
    logic                   fail_q;
    logic                   lock_lost_q;
    logic [RETRY_W-1:0]     retry_q;
    logic                   locked_s;

    // Lock synchronizer. Every decision below uses locked_s only.
    // NOTE: the synchronizer flops are reset too, so a lock seen before rst
    // cannot leak into the sequence that follows it.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pll_locked};
        end
    end

    assign locked_s = sync_q[SYNC_STAGES-1];

    // Sequencer. cnt_q counts up by default and is cleared on every state
    // entry. domain_rst_q is always a run of ones above a run of zeros;
    // releasing one more domain is a left shift that brings in a zero.
    // NOTE: non-blocking assignments throughout, so every branch reads the
    // pre-edge values no matter what order the assignments appear in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_PLL_RST;
            cnt_q        <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
            lock_lost_q  <= 1'b0;
            retry_q      <= '0;
        end else if (sw_relock) begin
            state_q      <= S_PLL_RST;
            cnt_q        <= '0;
            pll_rst_q    <= 1'b1;
            domain_rst_q <= '1;
            ready_q      <= 1'b0;
            fail_q       <= 1'b0;
            lock_lost_q  <= 1'b0;
            retry_q      <= '0;
        end else begin
            cnt_q <= cnt_q + 1'b1;
            case (state_q)
                S_PLL_RST: begin
                    if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) begin
                        state_q   <= S_WAIT_LOCK;
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b0;
                    end
                end
                S_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_q <= S_STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1)) begin
                        cnt_q     <= '0;
                        pll_rst_q <= 1'b1;
                        if (retry_q == RETRY_W'(MAX_RETRIES)) begin
                            state_q <= S_FAIL;
                            fail_q  <= 1'b1;
                        end else begin
                            state_q <= S_PLL_RST;
                            retry_q <= retry_q + 1'b1;
                        end
                    end
                end
                S_STABLE: begin
                    // A dropout restarts the timeout without costing a retry.
                    if (!locked_s) begin
                        state_q <= S_WAIT_LOCK;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_W'(LOCK_STABLE_CYCLES - 1)) begin
                        state_q      <= S_RELEASE;
                        cnt_q        <= '0;
                        domain_rst_q <= domain_rst_q << 1;
                    end
                end
                S_RELEASE: begin
                    if (!locked_s) begin
                        state_q      <= S_PLL_RST;
                        cnt_q        <= '0;
                        pll_rst_q    <= 1'b1;
                        domain_rst_q <= '1;
                    end else if (domain_rst_q == '0) begin
                        state_q <= S_RUN;
                        cnt_q   <= '0;
                        ready_q <= 1'b1;
                    end else if (cnt_q == CNT_W'(STAGE_GAP_CYCLES - 1)) begin
                        cnt_q        <= '0;
                        domain_rst_q <= domain_rst_q << 1;
                    end
                end
                S_RUN: begin
                    cnt_q <= cnt_q;
                    if (!locked_s) begin
                        state_q      <= S_PLL_RST;
                        cnt_q        <= '0;
                        pll_rst_q    <= 1'b1;
                        domain_rst_q <= '1;
                        ready_q      <= 1'b0;
                        lock_lost_q  <= 1'b1;
                        retry_q      <= '0;
                    end
                end
                S_FAIL: begin
                    cnt_q <= cnt_q;
                end
                default: begin
                    state_q      <= S_PLL_RST;
                    cnt_q        <= '0;
                    pll_rst_q    <= 1'b1;
                    domain_rst_q <= '1;
                    ready_q      <= 1'b0;
                end
            endcase
        end
    end

    assign pll_rst        = pll_rst_q;
    assign domain_rst_out = domain_rst_q;
    assign ready          = ready_q;
    assign fail           = fail_q;
    assign lock_lost      = lock_lost_q;
    assign retry_count    = retry_q;

endmodule

// File: tb/tb_pll_lock_reset_sequencer.sv
// tb_pll_lock_reset_sequencer
//
// Bench for pll_lock_reset_sequencer with small parameters. A reference model
// (a phase plus the number of edges spent in it, a queue as the lock delay
// line, and the release pattern worked out arithmetically from the elapsed
// count) is compared with the DUT after every clock. Fixed expectations come
// from a vector table for the nominal bring-up and from hand-written
// sequences for timeout/retry, debounce, loss in RUN, loss mid-release and
// reset priority. A randomized soak follows.

module tb_pll_lock_reset_sequencer;

    localparam int SYNC  = 2;
    localparam int PRC   = 4;
    localparam int TO    = 32;
    localparam int STB   = 8;
    localparam int ND    = 3;
    localparam int GAP   = 2;
    localparam int MAXR  = 2;
    localparam int RW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          pll_locked = 1'b0;
    logic          sw_relock = 1'b0;
    logic          pll_rst;
    logic [ND-1:0] domain_rst_out;
    logic          ready;
    logic          fail;
    logic          lock_lost;
    logic [RW-1:0] retry_count;

    int checks   = 0;
    int failures = 0;

    pll_lock_reset_sequencer #(
        .SYNC_STAGES(SYNC), .PLL_RST_CYCLES(PRC), .LOCK_TIMEOUT_CYCLES(TO),
        .LOCK_STABLE_CYCLES(STB), .NUM_DOMAINS(ND), .STAGE_GAP_CYCLES(GAP),
        .MAX_RETRIES(MAXR)
    ) dut (
        .clk(clk), .rst(rst), .pll_locked(pll_locked), .sw_relock(sw_relock),
        .pll_rst(pll_rst), .domain_rst_out(domain_rst_out), .ready(ready),
        .fail(fail), .lock_lost(lock_lost), .retry_count(retry_count)
    );

    always #5 clk = ~clk;

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef enum {M_PRST, M_WAIT, M_STABLE, M_RELEASE, M_RUN, M_FAIL} mphase_t;

    mphase_t m_phase = M_PRST;
    int      m_el    = 0;
    int      m_retry = 0;
    bit      m_lost  = 1'b0;
    bit      m_dly[$];

    task automatic m_enter(input mphase_t p);
        m_phase = p;
        m_el    = 0;
    endtask

    // One clock edge, using the inputs that are stable at that edge.
    task automatic model_edge();
        bit ls;
        if (rst) begin
            m_dly.delete();
            repeat (SYNC) m_dly.push_back(1'b0);
            m_enter(M_PRST);
            m_retry = 0;
            m_lost  = 1'b0;
        end else begin
            // locked_s at this edge is pll_locked as sampled SYNC edges ago.
            ls = m_dly.pop_front();
            m_dly.push_back(pll_locked);
            if (sw_relock) begin
                m_enter(M_PRST);
                m_retry = 0;
                m_lost  = 1'b0;
            end else begin
                case (m_phase)
                    M_PRST:    if (m_el + 1 == PRC) m_enter(M_WAIT); else m_el++;
                    M_WAIT: begin
                        if (ls) m_enter(M_STABLE);
                        else if (m_el + 1 == TO) begin
                            if (m_retry == MAXR) m_enter(M_FAIL);
                            else begin m_retry++; m_enter(M_PRST); end
                        end else m_el++;
                    end
                    M_STABLE: begin
                        if (!ls) m_enter(M_WAIT);
                        else if (m_el + 1 == STB) m_enter(M_RELEASE);
                        else m_el++;
                    end
                    M_RELEASE: begin
                        if (!ls) m_enter(M_PRST);
                        else if (m_el + 1 > (ND - 1) * GAP) m_enter(M_RUN);
                        else m_el++;
                    end
                    M_RUN: begin
                        if (!ls) begin m_enter(M_PRST); m_lost = 1'b1; m_retry = 0; end
                        else m_el++;
                    end
                    default: m_el++;
                endcase
            end
        end
    endtask

    function automatic logic [8:0] model_vec();
        logic [ND-1:0] dom;
        dom = '1;
        if (m_phase == M_RUN) dom = '0;
        if (m_phase == M_RELEASE)
            for (int k = 0; k < ND; k++) dom[k] = !(k * GAP <= m_el);
        return {(m_phase == M_PRST || m_phase == M_FAIL), dom, (m_phase == M_RUN),
                (m_phase == M_FAIL), m_lost, RW'(m_retry)};
    endfunction

    function automatic logic [8:0] dut_vec();
        return {pll_rst, domain_rst_out, ready, fail, lock_lost, retry_count};
    endfunction

    // Advance one clock; inputs are driven and outputs compared at negedge.
    task automatic step();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("model", {23'd0, dut_vec()}, {23'd0, model_vec()});
    endtask

    task automatic run_len(input logic want, output int n);
        n = 0;
        while (pll_rst === want && n < 200) begin
            n++;
            step();
        end
    endtask

    task automatic wait_ready(input string name);
        int k;
        k = 0;
        while (ready !== 1'b1 && k < 300) begin
            step();
            k++;
        end
        check(name, {31'd0, ready}, 32'd1);
    endtask

    task automatic relock_pulse();
        sw_relock = 1'b1;
        step();
        sw_relock = 1'b0;
    endtask

    // ---------------- nominal bring-up vectors ----------------
    typedef struct {
        logic          rst;
        logic          relock;
        logic          lock;
        int            reps;
        logic          e_pll_rst;
        logic [ND-1:0] e_dom;
        logic          e_ready;
        logic          e_fail;
        logic          e_lost;
        logic [RW-1:0] e_retry;
    } vec_t;

    localparam int NV = 12;
    vec_t tbl[NV];

    initial begin
        int n;
        int k;

        // Edge E0 is the last edge with rst high; pll_rst is high on the
        // sample after E0 and the following three, then WAIT_LOCK at E4.
        // Lock is raised 10 cycles after release, first sampled at E11.
        tbl[0]  = '{1'b1, 1'b0, 1'b0, 3,  1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[1]  = '{1'b0, 1'b0, 1'b0, 3,  1'b1, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[2]  = '{1'b0, 1'b0, 1'b0, 1,  1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[3]  = '{1'b0, 1'b0, 1'b0, 6,  1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[4]  = '{1'b0, 1'b0, 1'b1, 10, 1'b0, 3'b111, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[5]  = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[6]  = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 3'b110, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[7]  = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[8]  = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 3'b100, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[9]  = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 3'b000, 1'b0, 1'b0, 1'b0, 2'd0};
        tbl[10] = '{1'b0, 1'b0, 1'b1, 1,  1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0};
        tbl[11] = '{1'b0, 1'b0, 1'b1, 5,  1'b0, 3'b000, 1'b1, 1'b0, 1'b0, 2'd0};

        for (int i = 0; i < NV; i++) begin
            rst        = tbl[i].rst;
            sw_relock  = tbl[i].relock;
            pll_locked = tbl[i].lock;
            repeat (tbl[i].reps) step();
            check($sformatf("vec%0d", i), {23'd0, dut_vec()},
                  {23'd0, tbl[i].e_pll_rst, tbl[i].e_dom, tbl[i].e_ready,
                   tbl[i].e_fail, tbl[i].e_lost, tbl[i].e_retry});
        end

        // ---- loss in RUN: all resets back SYNC+1 edges after the drop ----
        pll_locked = 1'b0;
        step();
        step();
        check("loss_pre_dom", {29'd0, domain_rst_out}, 32'h0);
        check("loss_pre_ready", {31'd0, ready}, 32'd1);
        step();
        check("loss_dom", {29'd0, domain_rst_out}, 32'h7);
        check("loss_ready", {31'd0, ready}, 32'd0);
        check("loss_lost", {31'd0, lock_lost}, 32'd1);
        check("loss_pll_rst", {31'd0, pll_rst}, 32'd1);
        pll_locked = 1'b1;
        wait_ready("relock_ready");
        check("relock_lost_sticky", {31'd0, lock_lost}, 32'd1);

        // ---- rst and sw_relock together in RUN: rst wins ----
        rst = 1'b1;
        sw_relock = 1'b1;
        step();
        check("rstprio_vec", {23'd0, dut_vec()}, {23'd0, 1'b1, 3'b111, 5'b00000});
        rst = 1'b0;
        sw_relock = 1'b0;
        run_len(1'b1, n);
        check("rstprio_pll_rst_len", n, PRC);

        // ---- timeout with retries, then FAIL, then sw_relock ----
        pll_locked = 1'b0;
        relock_pulse();
        for (int a = 0; a <= MAXR; a++) begin
            check($sformatf("to_retry_prst%0d", a), {30'd0, retry_count}, a);
            run_len(1'b1, n);
            check($sformatf("to_pll_rst_len%0d", a), n, PRC);
            check($sformatf("to_retry_wait%0d", a), {30'd0, retry_count}, a);
            run_len(1'b0, n);
            check($sformatf("to_wait_len%0d", a), n, TO);
        end
        repeat (5) step();
        check("fail_vec", {23'd0, dut_vec()}, {23'd0, 1'b1, 3'b111, 1'b0, 1'b1, 1'b0, 2'd2});
        relock_pulse();
        check("fail_cleared", {23'd0, dut_vec()}, {23'd0, 1'b1, 3'b111, 5'b00000});

        // ---- debounce: 5 high, 1 low, then high ----
        run_len(1'b1, n);
        check("deb_pll_rst_len", n, PRC);
        pll_locked = 1'b1;
        repeat (5) step();
        pll_locked = 1'b0;
        step();
        pll_locked = 1'b1;
        k = 0;
        while (k < 50) begin
            step();
            k++;
            if (domain_rst_out !== 3'b111) break;
        end
        // Rise sampled at step 1, locked_s acts at step SYNC+1, then STB edges.
        check("deb_release_delay", k, SYNC + 1 + STB);
        check("deb_retry", {30'd0, retry_count}, 32'd0);
        wait_ready("deb_ready");

        // ---- loss mid-RELEASE: locked_s falls while pattern is 110 ----
        pll_locked = 1'b0;
        relock_pulse();
        run_len(1'b1, n);
        pll_locked = 1'b1;
        repeat (SYNC + STB) step();
        check("mid_pre_dom", {29'd0, domain_rst_out}, 32'h7);
        pll_locked = 1'b0;
        step();
        check("mid_dom0", {29'd0, domain_rst_out}, 32'h6);
        step();
        check("mid_dom1", {29'd0, domain_rst_out}, 32'h6);
        step();
        check("mid_back_vec", {23'd0, dut_vec()}, {23'd0, 1'b1, 3'b111, 5'b00000});

        // ---- randomized soak against the model ----
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 299) == 0);
            sw_relock = ($urandom_range(0, 149) == 0);
            if (pll_locked) pll_locked = ($urandom_range(0, 59) != 0);
            else            pll_locked = ($urandom_range(0, 99) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_reset_sequencer.md
# pll_lock_reset_sequencer

- Supervises the PLL lock output and generates the system reset sequence.
- Drives the PLL reset and waits for lock with a timeout and bounded retries.
- Debounces `locked` and releases per-clock-domain resets in a fixed staggered order.
- On any loss of lock, re-asserts all domain resets and re-arms the PLL.
- Sits between the PLL wrapper and the accelerator core/interconnect reset inputs. It is clocked from the free-running 50 MHz reference, never from a PLL output.

## Interface
Parameters:
- `SYNC_STAGES`, 2: flops in the `pll_locked` synchronizer (≥2).
- `PLL_RST_CYCLES`, 16: cycles `pll_rst` is held high per attempt (≥1).
- `LOCK_TIMEOUT_CYCLES`, 65536: cycles in WAIT_LOCK before an attempt fails.
- `LOCK_STABLE_CYCLES`, 1024: consecutive synchronized-high cycles required to accept lock.
- `NUM_DOMAINS`, 3: number of domain resets.
- `STAGE_GAP_CYCLES`, 8: cycles between successive domain reset releases (≥1).
- `MAX_RETRIES`, 3: retries after the first attempt before FAIL.

Ports:
- `clk` in 1: free-running reference clock.
- `rst` in 1: **synchronous, active-high reset.**
- `pll_locked` in 1: PLL lock; asynchronous to `clk`.
- `sw_relock` in 1: single-cycle request to restart the sequence.
- `pll_rst` out 1: PLL reset, active high.
- `domain_rst_out` out NUM_DOMAINS: per-domain resets, active high. Bit 0 is released first.
- `ready` out 1: all domains out of reset with lock held.
- `fail` out 1: retries exhausted.
- `lock_lost` out 1: sticky flag; lock dropped after RUN was reached. Cleared by `rst`/`sw_relock`.
- `retry_count` out clog2(MAX_RETRIES+1): attempts failed in the current episode.

## Operation
- **Lock synchronizer.** `pll_locked` passes through SYNC_STAGES flops; the output is `locked_s`. All decisions use `locked_s` only.
- **States:** PLL_RST, WAIT_LOCK, STABLE, RELEASE, RUN, FAIL. One shared down/up counter, reloaded on every state entry.
- **PLL_RST:**
  - `pll_rst`=1, all `domain_rst_out`=1.
  - After PLL_RST_CYCLES cycles → WAIT_LOCK.
- **WAIT_LOCK:**
  - `pll_rst`=0.
  - `locked_s`=1 → STABLE.
  - Counter reaches LOCK_TIMEOUT_CYCLES with no lock:
    - if `retry_count`==MAX_RETRIES → FAIL;
    - else `retry_count`+1 → PLL_RST.
- **STABLE:**
  - `locked_s`=0 → WAIT_LOCK, with the timeout counter restarted and the retry not incremented.
  - After LOCK_STABLE_CYCLES consecutive high cycles → RELEASE.
- **RELEASE:**
  - `domain_rst_out[0]` falls on the first edge in RELEASE.
  - `domain_rst_out[k]` falls exactly k·STAGE_GAP_CYCLES cycles after bit 0.
  - One cycle after the last bit falls → RUN.
  - `locked_s`=0 at any point → all bits high next edge, `lock_lost` unchanged, → PLL_RST.
- **RUN:**
  - `ready`=1.
  - `locked_s`=0 → next edge: all `domain_rst_out`=1, `ready`=0, `lock_lost`=1, `retry_count`=0, → PLL_RST.
- **FAIL:**
  - `fail`=1, `pll_rst`=1, all `domain_rst_out`=1.
  - Exited only by `rst` or `sw_relock`.
- **`sw_relock`** (any state):
  - next edge → PLL_RST;
  - `retry_count`=0, `fail`=0, `lock_lost`=0, `ready`=0;
  - all domain resets asserted.
- **Priority:** `rst` > `sw_relock` > lock loss > counter expiry.
- **Monotonic release:** `domain_rst_out` bits are never released out of order. The release pattern is always a prefix of low bits.

## Timing
- Reset values, which also hold during `rst`:
  - `pll_rst`=1, `domain_rst_out`=all 1, `ready`=0, `fail`=0, `lock_lost`=0, `retry_count`=0;
  - state PLL_RST, synchronizer flops 0.
- **Outputs:** all outputs are registered; no combinational path from any input.
- **Lock acquisition latency:** `pll_locked` rise → `locked_s` rise takes SYNC_STAGES cycles.
- **Lock loss latency:** `pll_locked` fall in RUN → `domain_rst_out` all 1 and `ready`=0 takes SYNC_STAGES+1 cycles.
- **Minimum time** from WAIT_LOCK entry with lock already high to `ready`=1: SYNC_STAGES + LOCK_STABLE_CYCLES + (NUM_DOMAINS−1)·STAGE_GAP_CYCLES + 2 cycles.
- **Glitch rejection:** a `pll_locked` glitch shorter than one `clk` period may be missed or seen as a single cycle. Either outcome is legal; a seen glitch resets the STABLE count.
- **`sw_relock` during `rst`:** ignored.
- **`sw_relock` held high:** the block stays in PLL_RST for the duration.

## Test plan
Bench parameters: PLL_RST_CYCLES=4, LOCK_TIMEOUT_CYCLES=32, LOCK_STABLE_CYCLES=8, STAGE_GAP_CYCLES=2, NUM_DOMAINS=3, MAX_RETRIES=2, SYNC_STAGES=2.

- **Nominal bring-up:** release `rst`, raise `pll_locked` 10 cycles later →
  - `pll_rst` high exactly 4 cycles;
  - `domain_rst_out` goes 111→110→100→000 with 2-cycle gaps;
  - `ready`=1 one cycle after 000;
  - `fail`=0, `retry_count`=0.
- **Timeout with retries:** hold `pll_locked`=0 →
  - three `pll_rst` pulses of 4 cycles, each followed by 32 WAIT_LOCK cycles;
  - `retry_count` steps 0→1→2;
  - then `fail`=1, `pll_rst`=1, domains all 1.
  - Afterwards pulse `sw_relock` → `fail`=0, `retry_count`=0, new `pll_rst` pulse.
- **Debounce:** lock high 5 cycles, low 1, then high →
  - no release until 8 consecutive synchronized-high cycles;
  - `retry_count` unchanged.
- **Loss in RUN:** drop `pll_locked` after `ready` →
  - domains all 1 and `ready`=0 exactly 3 cycles later;
  - `lock_lost`=1;
  - `pll_rst` pulse; re-lock yields `ready` again with `lock_lost` still 1.
- **Loss mid-RELEASE:** drop lock when `domain_rst_out`=110 → all bits back to 111, no bit 1/2 release, return to PLL_RST.
- **Reset priority:** assert `rst` and `sw_relock` together in RUN → all outputs at reset values next edge; state PLL_RST.
